// File: rtl/piso_reg.sv
// piso_reg: parallel-in serial-out shift register with a valid/ready load
// handshake. A WIDTH-bit word is accepted on load_valid && load_ready and
// shifted out one bit per clock on q, qualified by q_valid. last marks the
// final bit of each word. Back-to-back words are supported with no gap cycle.
// q, q_valid, last and busy are flops; load_ready is decoded from registered
// state and held low while rst is asserted.

module piso_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  sr_r;
  logic [CW-1:0]     cnt_r;
  logic              q_r;
  logic              q_valid_r;
  logic              last_r;
  logic              busy_r;

  logic [WIDTH-1:0]  shifted_s;
  logic [CW-1:0]     cnt_inc_s;
  logic              at_last_s;
  logic              load_ready_s;
  logic              accept_s;

  // Bit that sits at the output end of a word for the configured direction.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    logic b;
    if (MSB_FIRST) begin
      b = w[WIDTH-1];
    end else begin
      b = w[0];
    end
    return b;
  endfunction

  // Next shift-register contents: move toward the output end, fill with zero.
  always_comb begin
    shifted_s = '0;
    if (MSB_FIRST) begin
      shifted_s = {sr_r[WIDTH-2:0], 1'b0};
    end else begin
      shifted_s = {1'b0, sr_r[WIDTH-1:1]};
    end
  end

  // Handshake decode from registered state; ready is blocked during reset.
  always_comb begin
    at_last_s    = (cnt_r == CNT_LAST);
    cnt_inc_s    = cnt_r + CNT_ONE;
    load_ready_s = 1'b0;
    if (rst) begin
      load_ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      load_ready_s = 1'b1;
    end else if (state_r == SHIFT) begin
      load_ready_s = at_last_s;
    end else begin
      load_ready_s = 1'b0;
    end
    accept_s = load_valid & load_ready_s;
  end

  // Control FSM, datapath and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      sr_r      <= '0;
      cnt_r     <= CNT_ZERO;
      q_r       <= 1'b0;
      q_valid_r <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r   <= SHIFT;
            sr_r      <= din;
            cnt_r     <= CNT_ZERO;
            q_r       <= head_bit(din);
            q_valid_r <= 1'b1;
            last_r    <= 1'b0;  // WIDTH >= 2, so the first bit is never the last
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            q_r       <= 1'b0;
            q_valid_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        SHIFT: begin
          if (!at_last_s) begin
            state_r   <= SHIFT;
            sr_r      <= shifted_s;
            cnt_r     <= cnt_inc_s;
            q_r       <= head_bit(shifted_s);
            q_valid_r <= 1'b1;
            last_r    <= (cnt_inc_s == CNT_LAST);
            busy_r    <= 1'b1;
          end else if (accept_s) begin
            // Next word starts immediately: no idle cycle between words.
            state_r   <= SHIFT;
            sr_r      <= din;
            cnt_r     <= CNT_ZERO;
            q_r       <= head_bit(din);
            q_valid_r <= 1'b1;
            last_r    <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            sr_r      <= '0;
            cnt_r     <= CNT_ZERO;
            q_r       <= 1'b0;
            q_valid_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          sr_r      <= '0;
          cnt_r     <= CNT_ZERO;
          q_r       <= 1'b0;
          q_valid_r <= 1'b0;
          last_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = load_ready_s;
  assign q          = q_r;
  assign q_valid    = q_valid_r;
  assign last       = last_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_piso_reg.sv
// Self-checking bench for piso_reg: one MSB-first and one LSB-first instance.
// Expected serial bits are pushed to a scoreboard queue when a load is driven
// and popped as the DUT presents each bit.

module tb_piso_reg;

  logic       clk;
  logic       rst;
  logic       load_valid, load_ready;
  logic [7:0] din;
  logic       q, q_valid, last, busy;
  logic       lv2, lr2;
  logic [7:0] din2;
  logic       q2, qv2, last2, busy2;

  int n_total;
  int n_pass;

  logic sb[$];
  logic sb_lsb[$];

  piso_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .din(din), .q(q), .q_valid(q_valid), .last(last), .busy(busy)
  );

  piso_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2),
    .din(din2), .q(q2), .q_valid(qv2), .last(last2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bit order for a word, pushed at the moment its load is driven.
  function automatic void push_word(input logic [7:0] w, input bit msb);
    for (int k = 0; k < 8; k++) begin
      if (msb) sb.push_back(w[7-k]);
      else     sb_lsb.push_back(w[k]);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; din = 8'h00; lv2 = 1'b0; din2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (q !== 1'b0)          $display("FAIL reset q got %b want 0", q);                   else n_pass++;
    n_total++; if (q_valid !== 1'b0)    $display("FAIL reset q_valid got %b want 0", q_valid);       else n_pass++;
    n_total++; if (last !== 1'b0)       $display("FAIL reset last got %b want 0", last);             else n_pass++;
    n_total++; if (busy !== 1'b0)       $display("FAIL reset busy got %b want 0", busy);             else n_pass++;
    n_total++; if (load_ready !== 1'b0) $display("FAIL reset load_ready got %b want 0", load_ready); else n_pass++;
    n_total++; if (lr2 !== 1'b0)        $display("FAIL reset lsb load_ready got %b want 0", lr2);    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (load_ready !== 1'b1) $display("FAIL release load_ready got %b want 1", load_ready); else n_pass++;
    n_total++; if (lr2 !== 1'b1)        $display("FAIL release lsb load_ready got %b want 1", lr2);    else n_pass++;
  endtask

  task automatic test_single_msb();
    logic eb;
    load_valid = 1'b1; din = 8'hA5; push_word(8'hA5, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin load_valid = 1'b0; din = 8'hFF; end
      if (sb.size() > 0) eb = sb.pop_front(); else eb = 1'bx;
      n_total++; if (q !== eb)                     $display("FAIL single q c%0d got %b want %b", i, q, eb);                    else n_pass++;
      n_total++; if (q_valid !== 1'b1)             $display("FAIL single q_valid c%0d got %b want 1", i, q_valid);            else n_pass++;
      n_total++; if (busy !== 1'b1)                $display("FAIL single busy c%0d got %b want 1", i, busy);                  else n_pass++;
      n_total++; if (last !== (i == 8))            $display("FAIL single last c%0d got %b want %b", i, last, i == 8);         else n_pass++;
      n_total++; if (load_ready !== (i == 8))      $display("FAIL single load_ready c%0d got %b want %b", i, load_ready, i == 8); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (q !== 1'b0)          $display("FAIL single idle q got %b want 0", q);                   else n_pass++;
    n_total++; if (q_valid !== 1'b0)    $display("FAIL single idle q_valid got %b want 0", q_valid);       else n_pass++;
    n_total++; if (busy !== 1'b0)       $display("FAIL single idle busy got %b want 0", busy);             else n_pass++;
    n_total++; if (last !== 1'b0)       $display("FAIL single idle last got %b want 0", last);             else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL single idle load_ready got %b want 1", load_ready); else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] words [2];
    logic eb;
    words[0] = 8'h01; words[1] = 8'hA5;
    for (int w = 0; w < 2; w++) begin
      lv2 = 1'b1; din2 = words[w]; push_word(words[w], 1'b0);
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk); #1;
        if (i == 1) begin lv2 = 1'b0; din2 = 8'h00; end
        if (sb_lsb.size() > 0) eb = sb_lsb.pop_front(); else eb = 1'bx;
        n_total++; if (q2 !== eb)          $display("FAIL lsb q w%0d c%0d got %b want %b", w, i, q2, eb);         else n_pass++;
        n_total++; if (qv2 !== 1'b1)       $display("FAIL lsb q_valid w%0d c%0d got %b want 1", w, i, qv2);       else n_pass++;
        n_total++; if (last2 !== (i == 8)) $display("FAIL lsb last w%0d c%0d got %b want %b", w, i, last2, i == 8); else n_pass++;
      end
      @(posedge clk); #1;
      n_total++; if (qv2 !== 1'b0)   $display("FAIL lsb idle q_valid w%0d got %b want 0", w, qv2);  else n_pass++;
      n_total++; if (busy2 !== 1'b0) $display("FAIL lsb idle busy w%0d got %b want 0", w, busy2);   else n_pass++;
      n_total++; if (lr2 !== 1'b1)   $display("FAIL lsb idle load_ready w%0d got %b want 1", w, lr2); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic eb;
    logic edge_c;
    load_valid = 1'b1; din = 8'hFF; push_word(8'hFF, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) din = 8'h0F;
      if (i == 9) load_valid = 1'b0;
      edge_c = (i == 8) || (i == 16);
      if (sb.size() > 0) eb = sb.pop_front(); else eb = 1'bx;
      n_total++; if (q !== eb)             $display("FAIL b2b q c%0d got %b want %b", i, q, eb);                   else n_pass++;
      n_total++; if (q_valid !== 1'b1)     $display("FAIL b2b q_valid c%0d got %b want 1", i, q_valid);           else n_pass++;
      n_total++; if (busy !== 1'b1)        $display("FAIL b2b busy c%0d got %b want 1", i, busy);                 else n_pass++;
      n_total++; if (last !== edge_c)      $display("FAIL b2b last c%0d got %b want %b", i, last, edge_c);        else n_pass++;
      n_total++; if (load_ready !== edge_c) $display("FAIL b2b load_ready c%0d got %b want %b", i, load_ready, edge_c); else n_pass++;
      if (i == 8) push_word(8'h0F, 1'b1);
    end
    @(posedge clk); #1;
    n_total++; if (q_valid !== 1'b0) $display("FAIL b2b idle q_valid got %b want 0", q_valid); else n_pass++;
    n_total++; if (busy !== 1'b0)    $display("FAIL b2b idle busy got %b want 0", busy);       else n_pass++;
  endtask

  task automatic test_load_while_busy();
    logic eb;
    logic edge_c;
    load_valid = 1'b1; din = 8'hC3; push_word(8'hC3, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) load_valid = 1'b0;
      if (i == 9) load_valid = 1'b0;
      edge_c = (i == 8) || (i == 16);
      if (sb.size() > 0) eb = sb.pop_front(); else eb = 1'bx;
      n_total++; if (q !== eb)              $display("FAIL busyload q c%0d got %b want %b", i, q, eb);              else n_pass++;
      n_total++; if (q_valid !== 1'b1)      $display("FAIL busyload q_valid c%0d got %b want 1", i, q_valid);      else n_pass++;
      n_total++; if (last !== edge_c)       $display("FAIL busyload last c%0d got %b want %b", i, last, edge_c);   else n_pass++;
      n_total++; if (load_ready !== edge_c) $display("FAIL busyload load_ready c%0d got %b want %b", i, load_ready, edge_c); else n_pass++;
      if (i == 3) begin load_valid = 1'b1; din = 8'h00; end
      if (i == 8) push_word(8'h00, 1'b1);
    end
    @(posedge clk); #1;
    n_total++; if (q_valid !== 1'b0) $display("FAIL busyload idle q_valid got %b want 0", q_valid); else n_pass++;
    n_total++; if (sb.size() != 0)   $display("FAIL busyload scoreboard left %0d want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    logic eb;
    load_valid = 1'b1; din = 8'hAA; push_word(8'hAA, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) load_valid = 1'b0;
      if (sb.size() > 0) eb = sb.pop_front(); else eb = 1'bx;
      n_total++; if (q !== eb) $display("FAIL rstmid q c%0d got %b want %b", i, q, eb); else n_pass++;
    end
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_total++; if (q !== 1'b0)          $display("FAIL rstmid q got %b want 0", q);                   else n_pass++;
    n_total++; if (q_valid !== 1'b0)    $display("FAIL rstmid q_valid got %b want 0", q_valid);       else n_pass++;
    n_total++; if (last !== 1'b0)       $display("FAIL rstmid last got %b want 0", last);             else n_pass++;
    n_total++; if (busy !== 1'b0)       $display("FAIL rstmid busy got %b want 0", busy);             else n_pass++;
    n_total++; if (load_ready !== 1'b0) $display("FAIL rstmid load_ready got %b want 0", load_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_total++; if (load_ready !== 1'b1) $display("FAIL rstmid release load_ready got %b want 1", load_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (q_valid !== 1'b0)    $display("FAIL rstmid stale q_valid got %b want 0", q_valid); else n_pass++;
    load_valid = 1'b1; din = 8'h55; push_word(8'h55, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) load_valid = 1'b0;
      if (sb.size() > 0) eb = sb.pop_front(); else eb = 1'bx;
      n_total++; if (q !== eb)          $display("FAIL rstmid 55 q c%0d got %b want %b", i, q, eb);         else n_pass++;
      n_total++; if (last !== (i == 8)) $display("FAIL rstmid 55 last c%0d got %b want %b", i, last, i == 8); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (q_valid !== 1'b0) $display("FAIL rstmid 55 idle q_valid got %b want 0", q_valid); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0] rx;
    rx = 8'h00;
    load_valid = 1'b1; din = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) load_valid = 1'b0;
      n_total++; if (q_valid !== 1'b1) $display("FAIL loopback q_valid c%0d got %b want 1", i, q_valid); else n_pass++;
      if (q_valid === 1'b1) rx = {rx[6:0], q};
    end
    n_total++; if (rx !== 8'h3C) $display("FAIL loopback word got %h want 3c", rx); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_single_msb();
    test_lsb_first();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid_word();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
